// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// baud-divisor helper used by both the receive and transmit sides.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEFAULT = 16;
   localparam int unsigned DATA_BITS          = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_e;

   // Clock cycles per oversample tick, never less than one.
   function automatic int unsigned baud_div(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned os);
      int unsigned d;
      d = clk_hz / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Oversample tick generator: pulses once every DIV cycles; clear realigns the
// phase so ticks count from the cycle after the clear.
module rx_tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, start-bit glitch rejection, stop-bit
// check and a break guard that waits for the line to return high.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 38_000,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rxPin,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned     DIV      = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int unsigned     OS_W     = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]      BIT_LAST = 4'(DATA_BITS - 1);

   logic [1:0]           sync_q;
   logic                 rx_s;
   logic                 tick;
   logic                 tick_clear;
   rx_state_e            state_q;
   logic [OS_W-1:0]      os_cnt_q;
   logic [3:0]           bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;

   // Two-flop synchronizer; idles high so reset cannot fake a start bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rxPin};
      end
   end

   assign rx_s       = sync_q[1];
   assign tick_clear = (state_q == IDLE) && !rx_s;

   rx_tick_gen #(.DIV(DIV)) u_tick (
      .clock (clock),
      .reset (reset),
      .clear (tick_clear),
      .tick  (tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         os_cnt_q  <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q  <= START;
                  os_cnt_q <= '0;
                  busy     <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (os_cnt_q == OS_HALF) begin
                     os_cnt_q <= '0;
                     if (rx_s) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                     end else begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                     end
                  end else begin
                     os_cnt_q <= os_cnt_q + OS_W'(1);
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (os_cnt_q == OS_LAST) begin
                     os_cnt_q  <= '0;
                     shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == BIT_LAST) begin
                        state_q <= STOP;
                     end
                  end else begin
                     os_cnt_q <= os_cnt_q + OS_W'(1);
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (os_cnt_q == OS_LAST) begin
                     os_cnt_q <= '0;
                     if (rx_s) begin
                        data    <= shift_q;
                        valid   <= 1'b1;
                        state_q <= IDLE;
                        busy    <= 1'b0;
                     end else begin
                        frame_err <= 1'b1;
                        state_q   <= WAIT_HIGH;
                     end
                  end else begin
                     os_cnt_q <= os_cnt_q + OS_W'(1);
                  end
               end
            end
            WAIT_HIGH: begin
               // Hold off until a break releases, or it would look like a new start.
               if (rx_s) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=4 (64-cycle bits); a scoreboard holds the
// expected byte and arrival cycle for every frame that should be accepted.
module tb_uart_rx;

   localparam int BIT_CYC = 64;
   localparam int LAT     = 611;   // rxPin fall (tb cycle) to valid-high (tb cycle)

   logic       clock = 1'b0;
   logic       reset;
   logic       rxPin;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   typedef struct {
      logic [7:0] b;
      int         due;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   fe_cnt = 0;
   int   fe_cyc = -1;

   uart_rx #(.CLK_HZ(2_432_000), .BAUD(38_000)) dut (
      .clock     (clock),
      .reset     (reset),
      .rxPin     (rxPin),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Output monitor: pops the scoreboard on every valid pulse.
   always @(negedge clock) begin
      if (valid) begin
         check("valid_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("rx_data", 32'(data), 32'(e.b));
            check("valid_cycle", 32'(cyc), 32'(e.due));
         end
      end
      if (frame_err) begin
         fe_cnt++;
         fe_cyc = cyc;
      end
      if (valid || frame_err) check("valid_ferr_exclusive", 32'(valid & frame_err), 32'd0);
   end

   // Drives the first nbits of {stop, byte, start}; entered and left on a negedge.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits,
                             input bit expect_ok, output int fall);
      logic [9:0] fr;
      fr   = {stop, b, 1'b0};
      fall = cyc;
      if (expect_ok && nbits == 10) q.push_back('{b: b, due: cyc + LAT});
      for (int i = 0; i < nbits; i++) begin
         rxPin = fr[i];
         repeat (BIT_CYC) @(negedge clock);
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clock);
      check(tag, 32'(q.size()), 32'd0);
   endtask

   initial begin
      int   fall;
      int   fe0;
      logic bsy;

      // Reset with the line idle
      rxPin = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_data", 32'(data), 32'h00);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clock);

      // Single byte
      send_frame(8'hA5, 1'b1, 10, 1'b1, fall);
      drain("drain_a5");
      check("a5_no_ferr", 32'(fe_cnt), 32'd0);
      check("a5_data_hold", 32'(data), 32'hA5);
      check("a5_busy_low", 32'(busy), 32'd0);
      repeat (20) @(negedge clock);

      // Start-bit glitch shorter than half a bit
      rxPin = 1'b0;
      repeat (20) @(negedge clock);
      rxPin = 1'b1;
      bsy   = 1'b1;
      for (int i = 0; i < 40 && bsy; i++) begin
         @(negedge clock);
         bsy = busy;
      end
      check("glitch_busy_clear", 32'(bsy), 32'd0);
      repeat (100) @(negedge clock);
      check("glitch_data_hold", 32'(data), 32'hA5);

      // Framing error followed by a held break
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 10, 1'b0, fall);
      repeat (200) @(negedge clock);
      check("ferr_count", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_cycle", 32'(fe_cyc), 32'(fall + LAT));
      check("ferr_data_hold", 32'(data), 32'hA5);
      check("ferr_busy_break", 32'(busy), 32'd1);
      rxPin = 1'b1;
      repeat (4) @(negedge clock);
      check("ferr_busy_release", 32'(busy), 32'd0);
      repeat (20) @(negedge clock);
      send_frame(8'h5A, 1'b1, 10, 1'b1, fall);
      drain("drain_5a");

      // Back-to-back frames, no idle gap
      repeat (10) @(negedge clock);
      send_frame(8'h00, 1'b1, 10, 1'b1, fall);
      send_frame(8'hFF, 1'b1, 10, 1'b1, fall);
      drain("drain_b2b");
      check("b2b_data", 32'(data), 32'hFF);

      // Reset in the middle of data bit 4
      repeat (10) @(negedge clock);
      send_frame(8'h81, 1'b1, 5, 1'b0, fall);
      rxPin = 1'b0;
      repeat (BIT_CYC / 2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_data", 32'(data), 32'h00);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_ferr", 32'(frame_err), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      rxPin = 1'b1;
      repeat (700) @(negedge clock);
      check("midrst_data_after", 32'(data), 32'h00);
      send_frame(8'h7E, 1'b1, 10, 1'b1, fall);
      drain("drain_7e");

      repeat (10) @(negedge clock);
      check("total_ferr", 32'(fe_cnt), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver that recovers bytes from the serial stream produced by the sensor transmitter. It sits at the receiving end of `txPin` and consumes the transmitter's output. It oversamples the line 16x, validates the start bit, samples data at bit centres, checks the stop bit, and presents each good byte with a one-cycle strobe. Its outputs drive the downstream display/logging logic.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 38_000: line bit rate; matches the transmitter's 38 kHz bit clock.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥ 4.

Ports:
- `clock`, in, 1: the only clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `rxPin`, in, 1: asynchronous serial line; idles high.
- `data`, out, 8: last correctly framed byte.
- `valid`, out, 1: one-cycle pulse; `data` is new in that same cycle.
- `frame_err`, out, 1: one-cycle pulse when the stop bit samples low.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- **Synchronizer:** `rxPin` passes through 2 flops before use; call the result `rx_s`. Both flops reset to 1.
- **Tick generator:**
  - Divisor `DIV = max(1, CLK_HZ/(BAUD*OVERSAMPLE))`, integer floor.
  - The counter runs 0..DIV-1 and `tick` pulses when it equals DIV-1.
  - The counter is cleared in the cycle a start is detected, so ticks are phase-aligned to the start edge.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH. Reset enters IDLE.
- **IDLE:** when `rx_s`=0, go to START and clear the tick counter and the tick-count register.
- **START:** on the (OVERSAMPLE/2)th tick, sample `rx_s`.
  - If 0, go to DATA with the bit index at 0.
  - If 1, it was a glitch: go to IDLE with no output.
- **DATA:**
  - Every OVERSAMPLE ticks, sample `rx_s` into a shift register, LSB first.
  - After the 8th sample, go to STOP.
- **STOP:** after OVERSAMPLE ticks, sample `rx_s`.
  - If 1: load `data` from the shift register, pulse `valid`, go to IDLE.
  - If 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. This prevents a break condition from retriggering reception.
- **Reset values:** `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, shift register = 0, all counters = 0.
- **Widths:**
  - Tick count: $clog2(OVERSAMPLE) bits.
  - Bit index: 3 bits plus a done flag.
  - Divider: $clog2(DIV) bits, minimum 1.
  - All counts wrap only by explicit clear; there is no free-running overflow.

## Timing
- Detection happens in the cycle where `rx_s` is first 0 in IDLE, i.e. 2–3 cycles after the `rxPin` falling edge.
- Stop-bit sample: at the tick number (OVERSAMPLE/2 + 9·OVERSAMPLE) = 152 after detection, i.e. 152·DIV cycles after detection.
- `valid` or `frame_err` is registered and high in the cycle after the stop-sample tick, for exactly 1 cycle.
- `valid` and `frame_err` are never high in the same cycle.
- Back-to-back frames:
  - IDLE is re-entered half a bit before the stop bit ends.
  - A start bit immediately following the stop bit is detected with no lost frame.
- Reset mid-frame takes priority over all transitions. It forces IDLE and the reset values in the next cycle, and no `valid` results from the aborted frame.
- `busy` rises the cycle after detection. It falls in the same cycle that `valid` pulses, or when leaving WAIT_HIGH.
- Inputs are sampled only on `tick`. `reset` and IDLE start detection are evaluated every cycle.

## Structure
- Package `uart_pkg`:
  - State enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - `OVERSAMPLE_DEFAULT`=16.
  - `DATA_BITS`=8.
  - A `baud_div(clk_hz, baud, os)` constant function, shareable with the transmit side.
- Sub-module `rx_tick_gen`: parameter `DIV`; inputs `clock`, `reset`, `clear`; output `tick`.
- The FSM, synchronizer and shift register live in `uart_rx`.

## Test plan
All scenarios use parameters `CLK_HZ`=2_432_000, `BAUD`=38_000, which gives DIV=4 and a bit time of 64 cycles.
1. **Reset:** assert `reset` for 3 cycles with `rxPin`=1. Required: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0.
2. **Single byte:** drive 0xA5 in 8N1 format. Required: one `valid` pulse exactly 152·4+1 cycles after the detection cycle, with `data`=0xA5 and `frame_err` never high.
3. **Glitch:** drive `rxPin` low for 20 cycles (less than half a bit = 32 cycles), then high. Required: no `valid`, and `busy` returns to 0 within 40 cycles.
4. **Framing error:**
   - Drive 0x3C with the stop bit low, then hold the line low for 200 cycles.
   - Required: one `frame_err` pulse, `data` stays 0xA5, `busy` stays 1 until `rxPin` returns high.
   - A following 0x5A is then received correctly.
5. **Back-to-back:** send 0x00 then 0xFF with no idle gap. Required: two `valid` pulses 640 cycles apart, with `data`=0x00 then 0xFF.
6. **Reset mid-frame:**
   - Assert `reset` during data bit 4 of 0x81.
   - Required: reset values next cycle and no `valid`.
   - A subsequent 0x7E is received correctly.
